// File: rtl/axi4_lite_write_master_if.sv
// Core-side request port and AXI4-Lite write channels (AW, W, B) for axi4_lite_write_master.
// Modport master is the initiator's view; modport slave is the core/interconnect side.
interface axi4_lite_write_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Core side
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_ready;
    logic                  wr_done;
    logic [1:0]            wr_resp;
    logic                  wr_timeout;

    // AXI4-Lite write channels
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [3:0]            m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    modport master (
        input  wr_req, wr_addr, wr_data, wr_strb,
        output wr_ready, wr_done, wr_resp, wr_timeout,
        output m_axi_awaddr, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output wr_req, wr_addr, wr_data, wr_strb,
        input  wr_ready, wr_done, wr_resp, wr_timeout,
        input  m_axi_awaddr, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/axi4_lite_write_master.sv
// AXI4-Lite single-beat write initiator: one transaction in flight, AW and W issued together.
// Optional watchdog abort enabled by defining AXI_WR_TIMEOUT_EN.
module axi4_lite_write_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic                       clk,
    input logic                       rst,
    axi4_lite_write_master_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StXfer, StBresp} state_e;

    state_e                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            strb_q, strb_d;
    logic                  wr_done_q, wr_done_d;
    logic [1:0]            wr_resp_q, wr_resp_d;
    logic                  wr_timeout_q, wr_timeout_d;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    // Abort is registered, so it must be decided one cycle before the count hits the limit.
    localparam logic [CntW-1:0] AbortCnt = CntW'(TIMEOUT_CYCLES - 2);

    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        wr_done_d    = 1'b0;
        wr_resp_d    = wr_resp_q;
        wr_timeout_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.wr_req) begin
                    addr_d    = bus.wr_addr;
                    data_d    = bus.wr_data;
                    strb_d    = bus.wr_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StXfer;
                end
            end
            StXfer: begin
                // A channel whose valid is already low has completed its handshake.
                if (awvalid_q && bus.m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StBresp;
                end
            end
            StBresp: begin
                if (bus.m_axi_bvalid) begin
                    bready_d  = 1'b0;
                    wr_resp_d = bus.m_axi_bresp;
                    wr_done_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef AXI_WR_TIMEOUT_EN
        cnt_d = (state_q == StIdle) ? '0 : cnt_q + CntW'(1);
        // A B handshake in the abort cycle completes normally.
        if (state_q != StIdle && cnt_q == AbortCnt &&
            !(state_q == StBresp && bus.m_axi_bvalid)) begin
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            wr_done_d    = 1'b1;
            wr_resp_d    = 2'b10;
            wr_timeout_d = 1'b1;
            state_d      = StIdle;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            wr_done_q    <= 1'b0;
            wr_resp_q    <= 2'b00;
            wr_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            wr_done_q    <= wr_done_d;
            wr_resp_q    <= wr_resp_d;
            wr_timeout_q <= wr_timeout_d;
        end
    end

`ifdef AXI_WR_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign bus.wr_ready      = (state_q == StIdle);
    assign bus.wr_done       = wr_done_q;
    assign bus.wr_resp       = wr_resp_q;
    assign bus.wr_timeout    = wr_timeout_q;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = data_q;
    assign bus.m_axi_wstrb   = strb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi4_lite_write_master.sv
// Bench for axi4_lite_write_master: directed and randomized slave timing against a cycle model.
// Expected handshake/completion cycles are derived arithmetically from per-channel slave delays.
module tb_axi4_lite_write_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    axi4_lite_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_write_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL sim_budget expired: got no finish, want finish");
        $fatal(1, "simulation budget exceeded");
    end

    task automatic idle_inputs();
        bus.wr_req        = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.wr_strb       = '0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
    endtask

    // Runs one transaction starting in the current cycle (cycle 0). Slave asserts AWREADY from
    // cycle 1+da, WREADY from 1+dw, BVALID db cycles after BREADY first rises. Returns in the
    // wr_done cycle with inputs idled, so a following call is back-to-back.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int da, input int dw, input int db,
                           input logic [1:0] resp, input bit noise);
        int aw_cyc, w_cyc, hs, bv_cyc, done;
        logic exp_aw, exp_w, exp_b, exp_rdy;
        aw_cyc = 1 + da;
        w_cyc  = 1 + dw;
        hs     = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        bv_cyc = hs + 1 + db;
        done   = bv_cyc + 1;
        for (int c = 0; c <= done; c++) begin
            exp_aw  = (c >= 1) && (c <= aw_cyc);
            exp_w   = (c >= 1) && (c <= w_cyc);
            exp_b   = (c >= hs + 1) && (c < done);
            exp_rdy = (c == 0) || (c == done);
            n_checks++;
            if (bus.m_axi_awvalid !== exp_aw) begin
                n_fail++;
                $display("FAIL %s awvalid c=%0d got %b want %b", tag, c, bus.m_axi_awvalid, exp_aw);
            end
            n_checks++;
            if (bus.m_axi_wvalid !== exp_w) begin
                n_fail++;
                $display("FAIL %s wvalid c=%0d got %b want %b", tag, c, bus.m_axi_wvalid, exp_w);
            end
            n_checks++;
            if (bus.m_axi_bready !== exp_b) begin
                n_fail++;
                $display("FAIL %s bready c=%0d got %b want %b", tag, c, bus.m_axi_bready, exp_b);
            end
            n_checks++;
            if (bus.wr_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL %s wr_ready c=%0d got %b want %b", tag, c, bus.wr_ready, exp_rdy);
            end
            n_checks++;
            if (bus.wr_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL %s wr_timeout c=%0d got %b want 0", tag, c, bus.wr_timeout);
            end
            if (c > 0) begin
                n_checks++;
                if (bus.wr_done !== (c == done)) begin
                    n_fail++;
                    $display("FAIL %s wr_done c=%0d got %b want %b", tag, c, bus.wr_done, c == done);
                end
            end
            if (c == done) begin
                n_checks++;
                if (bus.wr_resp !== resp) begin
                    n_fail++;
                    $display("FAIL %s wr_resp got %b want %b", tag, bus.wr_resp, resp);
                end
            end
            if (exp_aw) begin
                n_checks++;
                if (bus.m_axi_awaddr !== addr) begin
                    n_fail++;
                    $display("FAIL %s awaddr c=%0d got %h want %h", tag, c, bus.m_axi_awaddr, addr);
                end
            end
            if (exp_w) begin
                n_checks++;
                if (bus.m_axi_wdata !== data || bus.m_axi_wstrb !== strb) begin
                    n_fail++;
                    $display("FAIL %s wpayload c=%0d got %h/%h want %h/%h", tag, c,
                             bus.m_axi_wdata, bus.m_axi_wstrb, data, strb);
                end
            end
            if (c == done) break;
            // Inputs for cycle c
            if (c == 0) begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = addr;
                bus.wr_data = data;
                bus.wr_strb = strb;
            end else begin
                bus.wr_req  = noise;
                bus.wr_addr = 32'h0000_0200;
                bus.wr_data = $urandom;
                bus.wr_strb = 4'($urandom);
            end
            bus.m_axi_awready = (c >= aw_cyc);
            bus.m_axi_wready  = (c >= w_cyc);
            bus.m_axi_bvalid  = (c >= bv_cyc);
            bus.m_axi_bresp   = resp;
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        n_checks++;
        if (bus.m_axi_awvalid !== 1'b0 || bus.m_axi_wvalid !== 1'b0 || bus.m_axi_bready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids got %b%b%b want 000", bus.m_axi_awvalid, bus.m_axi_wvalid,
                     bus.m_axi_bready);
        end
        n_checks++;
        if (bus.wr_ready !== 1'b1 || bus.wr_done !== 1'b0 || bus.wr_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_core got rdy=%b done=%b to=%b want 1 0 0", bus.wr_ready,
                     bus.wr_done, bus.wr_timeout);
        end
        n_checks++;
        if (bus.wr_resp !== 2'b00 || bus.m_axi_awaddr !== '0 || bus.m_axi_wdata !== '0 ||
            bus.m_axi_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_regs got resp=%b addr=%h data=%h strb=%h want zeros", bus.wr_resp,
                     bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic();
        run_txn("basic", 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        next_cycle();
    endtask

    task automatic test_w_late();
        run_txn("w_late", 32'h0000_1004, 32'h1234_5678, 4'h3, 0, 4, 0, 2'b00, 1'b0);
        next_cycle();
    endtask

    task automatic test_w_first();
        run_txn("w_first", 32'h0000_2008, 32'hCAFE_F00D, 4'hC, 3, 1, 0, 2'b01, 1'b0);
        next_cycle();
    endtask

    task automatic test_bresp_wait();
        run_txn("bresp_wait", 32'h0000_3000, 32'hA5A5_5A5A, 4'h9, 0, 0, 10, 2'b10, 1'b1);
        next_cycle();
        n_checks++;
        if (bus.wr_done !== 1'b0 || bus.wr_ready !== 1'b1 || bus.m_axi_awvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bresp_wait_after got done=%b rdy=%b awv=%b want 0 1 0", bus.wr_done,
                     bus.wr_ready, bus.m_axi_awvalid);
        end
    endtask

    task automatic test_back_to_back();
        run_txn("b2b0", 32'h0000_4000, 32'h0000_0001, 4'h1, 0, 0, 0, 2'b00, 1'b0);
        run_txn("b2b1", 32'h0000_4004, 32'h0000_0002, 4'h2, 0, 0, 0, 2'b11, 1'b0);
        run_txn("b2b2", 32'h0000_4008, 32'h0000_0003, 4'h4, 0, 0, 0, 2'b00, 1'b0);
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus.wr_req  = 1'b1;
        bus.wr_addr = 32'h0000_5000;
        bus.wr_data = 32'h5555_AAAA;
        bus.wr_strb = 4'hF;
        next_cycle();
        idle_inputs();
        n_checks++;
        if (bus.m_axi_awvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre awvalid got %b want 1", bus.m_axi_awvalid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.m_axi_awvalid !== 1'b0 || bus.m_axi_wvalid !== 1'b0 || bus.m_axi_bready !== 1'b0 ||
            bus.wr_ready !== 1'b1 || bus.wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid got awv=%b wv=%b br=%b rdy=%b done=%b want 0 0 0 1 0",
                     bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.wr_ready,
                     bus.wr_done);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        n_checks++;
        if (bus.wr_done !== 1'b0 || bus.wr_ready !== 1'b1 || bus.m_axi_awvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after got done=%b rdy=%b awv=%b want 0 1 0", bus.wr_done,
                     bus.wr_ready, bus.m_axi_awvalid);
        end
    endtask

`ifdef AXI_WR_TIMEOUT_EN
    task automatic test_timeout();
        bus.wr_req  = 1'b1;
        bus.wr_addr = 32'h0000_6000;
        bus.wr_data = 32'h6666_6666;
        bus.wr_strb = 4'hF;
        for (int c = 1; c <= int'(TO); c++) begin
            next_cycle();
            bus.wr_req = 1'b0;
            n_checks++;
            if (c < int'(TO)) begin
                if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_wvalid !== 1'b1 || bus.wr_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_wait c=%0d got awv=%b wv=%b done=%b want 1 1 0", c,
                             bus.m_axi_awvalid, bus.m_axi_wvalid, bus.wr_done);
                end
            end else begin
                if (bus.wr_done !== 1'b1 || bus.wr_timeout !== 1'b1 || bus.wr_resp !== 2'b10 ||
                    bus.m_axi_awvalid !== 1'b0 || bus.m_axi_wvalid !== 1'b0 ||
                    bus.wr_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_fire got done=%b to=%b resp=%b awv=%b wv=%b rdy=%b want 1 1 10 0 0 1",
                             bus.wr_done, bus.wr_timeout, bus.wr_resp, bus.m_axi_awvalid,
                             bus.m_axi_wvalid, bus.wr_ready);
                end
            end
        end
        idle_inputs();
        run_txn("after_timeout", 32'h0000_6004, 32'h7777_0000, 4'h5, 1, 0, 2, 2'b00, 1'b0);
        next_cycle();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_txn("random", $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) next_cycle();
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_late();
        test_w_first();
        test_bresp_wait();
        test_back_to_back();
        test_reset_mid();
`ifdef AXI_WR_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
